// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer.
// Holds the state encoding, default geometry and a one-hot decoder.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NCH_DEF    = 4;
    localparam int W_DEF      = 1;
    localparam int ONEHOT_MAX = 64;

    // Callers size-cast the result down to their own channel count.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx);
        logic [ONEHOT_MAX-1:0] v;
        v = {{(ONEHOT_MAX-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

endpackage

// File: rtl/tdm_demux_fsm.sv
// Frame-alignment controller: tracks the channel slot and detects framing violations.
// Exports a capture enable and slot index to the datapath.
//
// state | meaning
// HUNT  | waiting for a sample tagged sof; untagged samples are dropped
// RUN   | aligned; ch_cnt names the slot the next sample belongs to
module tdm_demux_fsm
    import tdm_pkg::*;
#(
    parameter  int NCH = NCH_DEF,
    localparam int CW  = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din_vld,
    input  logic          sof,
    output logic          cap_en,
    output logic [CW-1:0] slot,
    output logic          frame_end,
    output logic          locked,
    output logic          sync_err
);

    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    state_t        state;
    logic [CW-1:0] ch_cnt;
    logic          start;
    logic          mid;
    logic          lost;

    assign start     = din_vld & sof;
    assign mid       = din_vld & ~sof & (state == RUN) & (ch_cnt != '0);
    assign lost      = din_vld & ~sof & (state == RUN) & (ch_cnt == '0);
    assign cap_en    = start | mid;
    assign slot      = sof ? '0 : ch_cnt;
    assign frame_end = mid & (ch_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            ch_cnt   <= '0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (start) begin
                // A sof while a frame is partly collected is an early restart.
                sync_err <= (state == RUN) && (ch_cnt != '0);
                state    <= RUN;
                locked   <= 1'b1;
                ch_cnt   <= CW'(1);
            end else if (mid) begin
                ch_cnt <= ch_cnt + CW'(1);
            end else if (lost) begin
                sync_err <= 1'b1;
                state    <= HUNT;
                locked   <= 1'b0;
                ch_cnt   <= '0;
            end
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// 1-to-NCH time-division demultiplexer: steers serial samples into channel slots
// and presents each complete frame with a one-cycle valid pulse.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter  int NCH = NCH_DEF,
    parameter  int W   = W_DEF,
    localparam int CW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     din,
    input  logic             din_vld,
    input  logic             sof,
    output logic [NCH*W-1:0] dout,
    output logic             frame_vld,
    output logic [NCH-1:0]   ch_stb,
    output logic             locked,
    output logic             sync_err
);

    logic          cap_en;
    logic [CW-1:0] slot;
    logic          frame_end;

    // The last slot goes straight into dout, so only NCH-1 slots are buffered.
    logic [(NCH-1)*W-1:0] shadow;

    tdm_demux_fsm #(.NCH(NCH)) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_vld   (din_vld),
        .sof       (sof),
        .cap_en    (cap_en),
        .slot      (slot),
        .frame_end (frame_end),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            dout      <= '0;
            frame_vld <= 1'b0;
            ch_stb    <= '0;
        end else begin
            frame_vld <= frame_end;
            ch_stb    <= cap_en ? NCH'(onehot(32'(slot))) : '0;
            if (cap_en && !frame_end) begin
                shadow[32'(slot)*W +: W] <= din;
            end
            if (frame_end) begin
                dout <= {din, shadow};
            end
        end
    end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Sequential 1-to-NCH time-division demultiplexer. It is the receive end of the 4:1 channel-select mux path.
- Accepts a serial stream of W-bit samples tagged with a start-of-frame marker and steers each sample to its channel slot.
- Presents a complete, registered NCH-wide frame with a one-cycle valid pulse.
- Sits between the serial link and the per-channel consumers in the lab datapath.

Parameters:
- NCH, 4, number of channels per frame; power of two, at least 2.
- W, 1, bits per channel sample.
- CW, $clog2(NCH), localparam; channel counter width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  W  serial sample
- din_vld  input  1  din carries a sample this cycle
- sof  input  1  qualified by din_vld; this sample is channel 0
- dout  output  NCH*W  last complete frame; channel k at dout[k*W +: W]
- frame_vld  output  1  one-cycle pulse; dout updated this cycle
- ch_stb  output  NCH  one-hot pulse naming the channel slot accepted last cycle
- locked  output  1  high while in RUN
- sync_err  output  1  one-cycle pulse on a framing violation

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=HUNT, ch_cnt=0, shadow=0, dout=0, frame_vld=0, ch_stb=0, locked=0, sync_err=0.
- Reset mid-frame discards the partial frame immediately. dout returns to 0.
- Samples are accepted only when din_vld=1. With din_vld=0, all state holds and all pulses deassert.
- All outputs are registered. Latency is 1 clk from the accepting edge.

HUNT:
- din_vld & !sof: sample discarded, no pulses.
- din_vld & sof: shadow[0]<=din, ch_stb<=1, ch_cnt<=1, go RUN.

RUN, sample with ch_cnt=0:
- sof: start a new frame exactly as from HUNT.
- !sof: sync_err pulse, go HUNT, sample discarded.

RUN, sample with 0<ch_cnt<NCH-1:
- !sof: shadow[ch_cnt]<=din, ch_stb<=onehot(ch_cnt), ch_cnt++.
- sof: early frame start. sync_err pulse, partial frame discarded, shadow[0]<=din, ch_cnt<=1, stay RUN. dout is not updated.

RUN, sample with ch_cnt=NCH-1:
- !sof: dout<={din, shadow[NCH-2:0]}, frame_vld pulse, ch_stb<=onehot(NCH-1), ch_cnt wraps to 0.
- sof: handled as early frame start, as above.

Counter and output rules:
- ch_cnt wraps modulo NCH. Pure CW-bit arithmetic, no overflow handling needed.
- locked=(state==RUN), registered.
- frame_vld and sync_err are never high in the same cycle.
- dout changes only on a frame_vld cycle.
- Back-to-back frames with din_vld held high give one frame_vld every NCH cycles.

Decomposition:
- Shared package tdm_pkg holds the state encoding (HUNT=1'b0, RUN=1'b1), the default NCH/W, and a onehot function.
- One natural sub-module: tdm_demux_fsm. It owns the state, ch_cnt, locked and sync_err, and exports the capture enable and slot index.
- The top level holds the shadow/dout registers and the ch_stb decode.

Test Plan:
All scenarios use NCH=4, W=4.
1. Reset, then stream A,B,C,D with sof on A and din_vld continuous. Required: ch_stb=1,2,4,8 one cycle behind each sample; frame_vld one pulse; dout=16'hDCBA; locked=1 from the cycle after A.
2. Same frame with din_vld gaps of 2 idle cycles between samples. Required: identical dout=16'hDCBA; no extra pulses; all state held across gaps.
3. In HUNT, send 5,6 without sof, then 1,2,3,4 with sof on 1. Required: 5 and 6 ignored; no sync_err; dout=16'h4321.
4. Send 1,2 (sof on 1), then 7(sof),8,9,A. Required: sync_err pulse at 7; no frame_vld for the partial frame; then dout=16'hA987 with frame_vld.
5. After a complete frame, send E without sof. Required: sync_err pulse, locked drops to 0, dout unchanged.
6. Assert rst_n=0 asynchronously between the 2nd and 3rd sample. Required: all outputs 0 before the next clk edge; on release, HUNT; the next full frame decodes correctly.
